// File: rtl/ps2_mouse_sequencer.sv
// Brings a PS/2 mouse into stream mode through ps2_controller (reset, sample rate, enable),
// then assembles 3-byte movement packets into signed deltas and button flags.
module ps2_mouse_sequencer #(
   parameter logic [7:0]  SAMPLE_RATE  = 8'd100,
   parameter logic [25:0] RESP_TIMEOUT = 26'd50_000_000,
   parameter logic [19:0] PKT_GAP      = 20'd500_000,
   parameter int unsigned MAX_RETRIES  = 3
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       restart,
   output logic [7:0] the_command,
   output logic       send_command,
   input  logic       command_was_sent,
   input  logic       error_communication_timed_out,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic       init_done,
   output logic       init_failed,
   output logic [8:0] dx,
   output logic [8:0] dy,
   output logic [2:0] buttons,
   output logic [1:0] overflow,
   output logic       packet_valid
);
   localparam int unsigned RESP_W  = 26;
   localparam int unsigned GAP_W   = 20;
   localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

   typedef enum logic [2:0] {
      SEND, WAIT_ACK, WAIT_BAT, WAIT_ID, NEXT, RETRY, FAIL, STREAM
   } state_t;

   state_t             state, state_n, ack_state;
   logic [1:0]         cmd_idx, cmd_idx_n;
   logic [RETRY_W-1:0] retry_cnt, retry_n;
   logic [RESP_W-1:0]  resp_timer;
   logic               resp_expired;
   logic [7:0]         cmd_byte;
   logic [1:0]         byte_idx;
   logic [GAP_W-1:0]   gap_timer;
   logic [6:0]         head;
   logic [7:0]         byte1;

   assign resp_expired = (resp_timer == RESP_TIMEOUT - 26'd1);
   // An ACK to the reset command is followed by the BAT result and device ID.
   assign ack_state = (received_data == 8'hFA) ? ((cmd_idx == 2'd0) ? WAIT_BAT : NEXT) : RETRY;

   always_comb begin
      case (cmd_idx_n)
         2'd0:    cmd_byte = 8'hFF;
         2'd1:    cmd_byte = 8'hF3;
         2'd2:    cmd_byte = SAMPLE_RATE;
         default: cmd_byte = 8'hF4;
      endcase
   end

   always_comb begin
      state_n   = state;
      cmd_idx_n = cmd_idx;
      retry_n   = retry_cnt;
      case (state)
         SEND: begin
            if (command_was_sent)
               state_n = received_data_en ? ack_state : WAIT_ACK;
            else if (error_communication_timed_out)
               state_n = RETRY;
         end
         WAIT_ACK: begin
            if (received_data_en)  state_n = ack_state;
            else if (resp_expired) state_n = RETRY;
         end
         WAIT_BAT: begin
            if (received_data_en)  state_n = (received_data == 8'hAA) ? WAIT_ID : RETRY;
            else if (resp_expired) state_n = RETRY;
         end
         WAIT_ID: begin
            if (received_data_en)  state_n = (received_data == 8'h00) ? NEXT : RETRY;
            else if (resp_expired) state_n = RETRY;
         end
         NEXT: begin
            retry_n = '0;
            if (cmd_idx == 2'd3) begin
               state_n = STREAM;
            end else begin
               cmd_idx_n = cmd_idx + 2'd1;
               state_n   = SEND;
            end
         end
         RETRY: begin
            retry_n = retry_cnt + RETRY_W'(1);
            state_n = (retry_n == RETRY_W'(MAX_RETRIES)) ? FAIL : SEND;
         end
         FAIL, STREAM: begin
            if (restart) begin
               state_n   = SEND;
               cmd_idx_n = 2'd0;
               retry_n   = '0;
            end
         end
         default: ;
      endcase
   end

   // Sequencer state, response timer and controller-facing outputs.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state        <= SEND;
         cmd_idx      <= 2'd0;
         retry_cnt    <= '0;
         resp_timer   <= '0;
         the_command  <= 8'h00;
         send_command <= 1'b0;
         init_done    <= 1'b0;
         init_failed  <= 1'b0;
      end else begin
         state     <= state_n;
         cmd_idx   <= cmd_idx_n;
         retry_cnt <= retry_n;
         if (state_n != state || received_data_en || !(state inside {WAIT_ACK, WAIT_BAT, WAIT_ID}))
            resp_timer <= '0;
         else
            resp_timer <= resp_timer + RESP_W'(1);
         send_command <= (state_n == SEND);
         if (state_n == SEND)
            the_command <= cmd_byte;
         init_done   <= (state_n == STREAM);
         init_failed <= (state_n == FAIL);
      end
   end

   // Stream-mode packet assembly with header resync and inter-byte gap drop.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         byte_idx     <= 2'd0;
         gap_timer    <= '0;
         head         <= 7'h00;
         byte1        <= 8'h00;
         dx           <= 9'h000;
         dy           <= 9'h000;
         buttons      <= 3'b000;
         overflow     <= 2'b00;
         packet_valid <= 1'b0;
      end else begin
         packet_valid <= 1'b0;
         if (state != STREAM || restart) begin
            byte_idx  <= 2'd0;
            gap_timer <= '0;
         end else if (received_data_en) begin
            gap_timer <= '0;
            case (byte_idx)
               2'd0: begin
                  if (received_data[3]) begin
                     head     <= {received_data[7:4], received_data[2:0]};
                     byte_idx <= 2'd1;
                  end
               end
               2'd1: begin
                  byte1    <= received_data;
                  byte_idx <= 2'd2;
               end
               default: begin
                  dx           <= {head[3], byte1};
                  dy           <= {head[4], received_data};
                  buttons      <= head[2:0];
                  overflow     <= head[6:5];
                  packet_valid <= 1'b1;
                  byte_idx     <= 2'd0;
               end
            endcase
         end else if (byte_idx != 2'd0) begin
            if (gap_timer == PKT_GAP - 20'd1) begin
               byte_idx  <= 2'd0;
               gap_timer <= '0;
            end else begin
               gap_timer <= gap_timer + GAP_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Bench for ps2_mouse_sequencer: scripted and random mouse responses checked against
// a command-order/outcome model and a byte-stream packet parser.
module tb_ps2_mouse_sequencer;
   localparam logic [7:0] SAMPLE_RATE  = 8'd100;
   localparam int         MAX_RETRIES  = 3;
   localparam int         RESP_TIMEOUT = 1000;
   localparam int         PKT_GAP      = 200;
   localparam int         WAIT_LIMIT   = 3000;

   localparam int K_OK = 0, K_NAK = 1, K_BAD = 2, K_CTRL_TO = 3, K_RESP_TO = 4,
                  K_BAT_BAD = 5, K_ID_BAD = 6;

   typedef struct packed {
      logic [8:0] dx;
      logic [8:0] dy;
      logic [2:0] buttons;
      logic [1:0] overflow;
   } pkt_t;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       restart = 1'b0;
   logic [7:0] the_command;
   logic       send_command;
   logic       command_was_sent = 1'b0;
   logic       error_communication_timed_out = 1'b0;
   logic [7:0] received_data = 8'h00;
   logic       received_data_en = 1'b0;
   logic       init_done, init_failed;
   logic [8:0] dx, dy;
   logic [2:0] buttons;
   logic [1:0] overflow;
   logic       packet_valid;

   int   errors = 0;
   int   checks = 0;
   pkt_t obs_q[$];

   ps2_mouse_sequencer #(
      .SAMPLE_RATE (SAMPLE_RATE),
      .RESP_TIMEOUT(26'(RESP_TIMEOUT)),
      .PKT_GAP     (20'(PKT_GAP)),
      .MAX_RETRIES (MAX_RETRIES)
   ) dut (
      .CLOCK_50                     (CLOCK_50),
      .reset                        (reset),
      .restart                      (restart),
      .the_command                  (the_command),
      .send_command                 (send_command),
      .command_was_sent             (command_was_sent),
      .error_communication_timed_out(error_communication_timed_out),
      .received_data                (received_data),
      .received_data_en             (received_data_en),
      .init_done                    (init_done),
      .init_failed                  (init_failed),
      .dx                           (dx),
      .dy                           (dy),
      .buttons                      (buttons),
      .overflow                     (overflow),
      .packet_valid                 (packet_valid)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50)
      if (packet_valid === 1'b1) obs_q.push_back({dx, dy, buttons, overflow});

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   function automatic logic [7:0] cmd_of(input int idx);
      case (idx)
         0:       return 8'hFF;
         1:       return 8'hF3;
         2:       return SAMPLE_RATE;
         default: return 8'hF4;
      endcase
   endfunction

   function automatic pkt_t decode(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      pkt_t p;
      int   x, y;
      x = int'(b1) - (b0[4] ? 256 : 0);
      y = int'(b2) - (b0[5] ? 256 : 0);
      p.dx       = 9'(x);
      p.dy       = 9'(y);
      p.buttons  = 3'(b0 % 8);
      p.overflow = 2'(b0 / 64);
      return p;
   endfunction

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      received_data    = b;
      received_data_en = 1'b1;
      tick();
      received_data_en = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   task automatic wait_send(output logic [7:0] cmd, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < WAIT_LIMIT; i++) begin
         if (send_command === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      cmd = the_command;
   endtask

   task automatic wait_settle();
      for (int i = 0; i < WAIT_LIMIT; i++) begin
         if (init_done === 1'b1 || init_failed === 1'b1 || send_command === 1'b1) break;
         tick();
      end
   endtask

   // Controller completes the transfer; optionally the response arrives in the same cycle.
   task automatic accept(input bit simul, input logic [7:0] rsp);
      idle(int'($urandom_range(0, 2)));
      command_was_sent = 1'b1;
      if (simul) begin
         received_data    = rsp;
         received_data_en = 1'b1;
      end
      tick();
      command_was_sent = 1'b0;
      received_data_en = 1'b0;
   endtask

   // Mouse/controller behaviour for one command attempt of the given outcome kind.
   task automatic do_attempt(input int idx, input int kind, input bit simul);
      logic [7:0] bad;
      int         k;
      k = kind;
      if (idx != 0 && k >= K_BAT_BAD) k = K_NAK;
      bad = 8'($urandom_range(0, 255));
      if (bad == 8'hFA) bad = 8'h12;
      case (k)
         K_OK: begin
            accept(simul, 8'hFA);
            if (!simul) begin
               idle(int'($urandom_range(0, 3)));
               send_byte(8'hFA);
            end
            if (idx == 0) begin
               idle(int'($urandom_range(0, 3)));
               send_byte(8'hAA);
               idle(int'($urandom_range(0, 3)));
               send_byte(8'h00);
            end
         end
         K_NAK: begin
            accept(simul, 8'hFE);
            if (!simul) send_byte(8'hFE);
         end
         K_BAD: begin
            accept(1'b0, 8'h00);
            send_byte(bad);
         end
         K_CTRL_TO: begin
            error_communication_timed_out = 1'b1;
            tick();
            error_communication_timed_out = 1'b0;
         end
         K_RESP_TO: accept(1'b0, 8'h00);
         K_BAT_BAD: begin
            accept(1'b0, 8'h00);
            send_byte(8'hFA);
            send_byte(8'hFC);
         end
         default: begin
            accept(1'b0, 8'h00);
            send_byte(8'hFA);
            send_byte(8'hAA);
            send_byte(8'h03);
         end
      endcase
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      checks++;
      if (send_command !== 1'b0) begin errors++; $display("FAIL reset_send_command got %b want 0", send_command); end
      checks++;
      if (the_command !== 8'h00) begin errors++; $display("FAIL reset_the_command got %h want 00", the_command); end
      checks++;
      if (init_done !== 1'b0 || init_failed !== 1'b0) begin
         errors++; $display("FAIL reset_status got done=%b failed=%b want 0/0", init_done, init_failed);
      end
      checks++;
      if ({dx, dy, buttons, overflow, packet_valid} !== 24'h0) begin
         errors++; $display("FAIL reset_packet got dx=%h dy=%h b=%b o=%b v=%b want all 0", dx, dy, buttons, overflow, packet_valid);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (send_command !== 1'b1 || the_command !== 8'hFF) begin
         errors++; $display("FAIL reset_first_cmd got send=%b cmd=%h want 1/ff", send_command, the_command);
      end
   endtask

   task automatic test_clean_init();
      logic [7:0] cmd;
      bit         seen;
      for (int idx = 0; idx < 4; idx++) begin
         wait_send(cmd, seen);
         checks++;
         if (!seen || cmd !== cmd_of(idx)) begin
            errors++; $display("FAIL clean_cmd%0d got %h seen=%b want %h", idx, cmd, seen, cmd_of(idx));
         end
         do_attempt(idx, K_OK, idx == 2);
      end
      checks++;
      if (init_done !== 1'b0 || init_failed !== 1'b0) begin
         errors++; $display("FAIL clean_next_cycle got done=%b failed=%b want 0/0", init_done, init_failed);
      end
      tick();
      checks++;
      if (init_done !== 1'b1 || init_failed !== 1'b0 || send_command !== 1'b0) begin
         errors++; $display("FAIL clean_done got done=%b failed=%b send=%b want 1/0/0", init_done, init_failed, send_command);
      end
   endtask

   task automatic test_packet();
      pkt_t e;
      obs_q.delete();
      send_byte(8'h39);
      idle(1);
      send_byte(8'h05);
      send_byte(8'hFB);
      idle(3);
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL pkt_count got %0d want 1", obs_q.size());
      end else begin
         e = decode(8'h39, 8'h05, 8'hFB);
         checks++;
         if (obs_q[0] !== e) begin errors++; $display("FAIL pkt_model got %h want %h", obs_q[0], e); end
      end
      idle(5);
      checks++;
      if (dx !== 9'h105 || dy !== 9'h1FB || buttons !== 3'b001 || overflow !== 2'b00) begin
         errors++; $display("FAIL pkt_hold got dx=%h dy=%h b=%b o=%b want 105/1fb/001/00", dx, dy, buttons, overflow);
      end
      obs_q.delete();
      send_byte(8'h05);
      idle(2);
      send_byte(8'h05);
      send_byte(8'h05);
      idle(3);
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL pkt_resync_discard got %0d packets want 0", obs_q.size()); end
      send_byte(8'h08);
      send_byte(8'h02);
      send_byte(8'h03);
      idle(3);
      e = decode(8'h08, 8'h02, 8'h03);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== e) begin
         errors++; $display("FAIL pkt_resync_next got n=%0d first=%h want 1/%h", obs_q.size(),
                            (obs_q.size() > 0) ? obs_q[0] : pkt_t'(0), e);
      end
   endtask

   task automatic test_gap();
      pkt_t e;
      obs_q.delete();
      send_byte(8'h08);
      send_byte(8'h10);
      idle(PKT_GAP + 50);
      send_byte(8'h08);
      send_byte(8'h01);
      send_byte(8'h02);
      idle(3);
      e = decode(8'h08, 8'h01, 8'h02);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== e || e.dx !== 9'd1 || e.dy !== 9'd2) begin
         errors++; $display("FAIL gap_drop got n=%0d first=%h want 1/%h", obs_q.size(),
                            (obs_q.size() > 0) ? obs_q[0] : pkt_t'(0), e);
      end
      obs_q.delete();
      send_byte(8'h28);
      idle(PKT_GAP - 50);
      send_byte(8'h07);
      idle(PKT_GAP - 50);
      send_byte(8'hF0);
      idle(3);
      e = decode(8'h28, 8'h07, 8'hF0);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== e) begin
         errors++; $display("FAIL gap_keep got n=%0d first=%h want 1/%h", obs_q.size(),
                            (obs_q.size() > 0) ? obs_q[0] : pkt_t'(0), e);
      end
   endtask

   task automatic test_random_packets();
      logic [7:0] stream[$];
      logic [7:0] held[3];
      pkt_t       exp_q[$];
      int         n;
      for (int p = 0; p < 25; p++) begin
         if ($urandom_range(0, 3) == 0) stream.push_back(8'($urandom_range(0, 255)) & 8'hF7);
         stream.push_back(8'($urandom_range(0, 255)) | 8'h08);
         stream.push_back(8'($urandom_range(0, 255)));
         stream.push_back(8'($urandom_range(0, 255)));
      end
      n = 0;
      foreach (stream[i]) begin
         if (n != 0 || stream[i][3] == 1'b1) begin
            held[n] = stream[i];
            n++;
            if (n == 3) begin
               exp_q.push_back(decode(held[0], held[1], held[2]));
               n = 0;
            end
         end
      end
      obs_q.delete();
      foreach (stream[i]) begin
         send_byte(stream[i]);
         idle(int'($urandom_range(0, 4)));
      end
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_pkt_count got %0d want %0d", obs_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_pkt%0d got %h want %h", i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_resend();
      logic [7:0] exp_cmd[7] = '{8'hFF, 8'hF3, 8'hF3, 8'h64, 8'h64, 8'h64, 8'hF4};
      int         kind[7]    = '{K_OK, K_NAK, K_OK, K_NAK, K_BAD, K_OK, K_OK};
      int         idx_of[7]  = '{0, 1, 1, 2, 2, 2, 3};
      logic [7:0] cmd;
      bit         seen;
      pulse_restart();
      for (int a = 0; a < 7; a++) begin
         wait_send(cmd, seen);
         checks++;
         if (!seen || cmd !== exp_cmd[a]) begin
            errors++; $display("FAIL resend_attempt%0d got %h seen=%b want %h", a, cmd, seen, exp_cmd[a]);
         end
         do_attempt(idx_of[a], kind[a], 1'b0);
      end
      wait_settle();
      checks++;
      if (init_done !== 1'b1 || init_failed !== 1'b0) begin
         errors++; $display("FAIL resend_done got done=%b failed=%b want 1/0", init_done, init_failed);
      end
   endtask

   task automatic test_give_up();
      logic [7:0] cmd;
      bit         seen;
      int         bad;
      pulse_restart();
      for (int a = 0; a < MAX_RETRIES; a++) begin
         wait_send(cmd, seen);
         checks++;
         if (!seen || cmd !== 8'hFF) begin
            errors++; $display("FAIL giveup_attempt%0d got %h seen=%b want ff", a, cmd, seen);
         end
         do_attempt(0, K_CTRL_TO, 1'b0);
      end
      wait_settle();
      checks++;
      if (init_failed !== 1'b1 || send_command !== 1'b0 || init_done !== 1'b0) begin
         errors++; $display("FAIL giveup_state got failed=%b send=%b done=%b want 1/0/0", init_failed, send_command, init_done);
      end
      bad = 0;
      send_byte(8'hFA);
      send_byte(8'hAA);
      for (int i = 0; i < 20; i++) begin
         if (send_command !== 1'b0 || init_failed !== 1'b1) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL giveup_hold got %0d bad cycles want 0", bad); end
      pulse_restart();
      wait_send(cmd, seen);
      checks++;
      if (!seen || cmd !== 8'hFF || init_failed !== 1'b0) begin
         errors++; $display("FAIL giveup_restart got %h seen=%b failed=%b want ff/1/0", cmd, seen, init_failed);
      end
   endtask

   task automatic test_resp_timeout();
      logic [7:0] cmd;
      bit         seen;
      int         cnt;
      wait_send(cmd, seen);
      accept(1'b0, 8'h00);
      send_byte(8'hFA);
      cnt = 0;
      while (send_command !== 1'b1 && cnt < WAIT_LIMIT) begin
         tick();
         cnt++;
      end
      checks++;
      if (cnt < RESP_TIMEOUT || cnt > RESP_TIMEOUT + 3 || the_command !== 8'hFF) begin
         errors++; $display("FAIL resp_timeout got %0d cycles cmd=%h want %0d..%0d/ff", cnt, the_command, RESP_TIMEOUT, RESP_TIMEOUT + 3);
      end
      accept(1'b0, 8'h00);
      send_byte(8'hFA);
      send_byte(8'hFC);
      cnt = 0;
      while (send_command !== 1'b1 && cnt < WAIT_LIMIT) begin
         tick();
         cnt++;
      end
      checks++;
      if (cnt > 4 || the_command !== 8'hFF) begin
         errors++; $display("FAIL bat_reject got %0d cycles cmd=%h want <=4/ff", cnt, the_command);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      tick();
      checks++;
      if (send_command !== 1'b0 || the_command !== 8'h00 || dx !== 9'h0 || dy !== 9'h0) begin
         errors++; $display("FAIL reset_mid got send=%b cmd=%h dx=%h dy=%h want 0/00/0/0", send_command, the_command, dx, dy);
      end
      idle(2);
      reset = 1'b0;
      tick();
      checks++;
      if (send_command !== 1'b1 || the_command !== 8'hFF) begin
         errors++; $display("FAIL reset_mid_resume got send=%b cmd=%h want 1/ff", send_command, the_command);
      end
   endtask

   task automatic test_random_init();
      for (int run = 0; run < 6; run++) begin
         int         idx, fails, kind;
         bit         expect_stream, done, seen;
         logic [7:0] cmd;
         idx = 0;
         fails = 0;
         expect_stream = 1'b0;
         done = 1'b0;
         for (int a = 0; a < 64 && !done; a++) begin
            wait_send(cmd, seen);
            checks++;
            if (!seen || cmd !== cmd_of(idx)) begin
               errors++; $display("FAIL rand_init run%0d attempt%0d got %h seen=%b want %h", run, a, cmd, seen, cmd_of(idx));
               done = 1'b1;
            end else begin
               kind = ($urandom_range(0, 99) < 35) ? int'($urandom_range(1, 6)) : K_OK;
               do_attempt(idx, kind, $urandom_range(0, 1) == 1);
               if (kind == K_OK) begin
                  fails = 0;
                  idx++;
                  if (idx == 4) begin expect_stream = 1'b1; done = 1'b1; end
               end else begin
                  fails++;
                  if (fails == MAX_RETRIES) done = 1'b1;
               end
            end
         end
         wait_settle();
         checks++;
         if (expect_stream) begin
            if (init_done !== 1'b1 || init_failed !== 1'b0) begin
               errors++; $display("FAIL rand_init run%0d outcome got done=%b failed=%b want 1/0", run, init_done, init_failed);
            end
         end else if (init_failed !== 1'b1 || init_done !== 1'b0 || send_command !== 1'b0) begin
            errors++; $display("FAIL rand_init run%0d outcome got done=%b failed=%b send=%b want 0/1/0", run, init_done, init_failed, send_command);
         end
         pulse_restart();
      end
   endtask

   initial begin
      test_reset();
      test_clean_init();
      test_packet();
      test_gap();
      test_random_packets();
      test_resend();
      test_give_up();
      test_resp_timeout();
      test_reset_mid();
      test_random_init();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_mouse_sequencer.md
Name: ps2_mouse_sequencer

Overview:
Drives the command side of ps2_controller to bring a PS/2 mouse from power-up into stream mode. It sends reset, sets the sample rate and enables data reporting, with ACK checking, timeouts and bounded retries. After that it assembles the 3-byte movement packets from received_data into signed deltas and button flags. It sits between ps2_controller and user logic, replacing any ad-hoc init wiring.

Parameters:
SAMPLE_RATE, 8'd100, rate byte sent after 0xF3
RESP_TIMEOUT, 26'd50_000_000, max cycles waiting for any expected response byte (1 s at 50 MHz)
PKT_GAP, 20'd500_000, max idle cycles between bytes of one packet (10 ms)
MAX_RETRIES, 3, failed attempts per command before giving up

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high
restart  in  1  pulse; re-runs init from STREAM or FAIL
the_command  out  8  to ps2_controller
send_command  out  1  to ps2_controller
command_was_sent  in  1  from ps2_controller
error_communication_timed_out  in  1  from ps2_controller
received_data  in  8  from ps2_controller
received_data_en  in  1  from ps2_controller, 1-cycle strobe
init_done  out  1  high while in STREAM
init_failed  out  1  high while in FAIL
dx  out  9  signed X delta, two's complement
dy  out  9  signed Y delta
buttons  out  3  {middle,right,left}
overflow  out  2  {y_ovf,x_ovf}
packet_valid  out  1  1-cycle strobe, fields valid same cycle

Behaviour:
- Reset: all outputs 0; state SEND with cmd_idx=0, retry_cnt=0, byte_idx=0, timers 0.
- Command list by cmd_idx: 0:0xFF, 1:0xF3, 2:SAMPLE_RATE, 3:0xF4.
- SEND: the_command=list[cmd_idx], send_command=1. On command_was_sent -> WAIT_ACK, send_command=0 next cycle. On error_communication_timed_out -> RETRY.
- received_data_en is honoured in SEND after command_was_sent and in every WAIT state; a response arriving while send_command is still high is not lost.
- WAIT_ACK: byte 0xFA -> WAIT_BAT if cmd_idx=0, else NEXT. Byte 0xFE, any other byte, or timer reaching RESP_TIMEOUT -> RETRY.
- WAIT_BAT: 0xAA -> WAIT_ID. 0xFC, other byte or timeout -> RETRY.
- WAIT_ID: 0x00 -> NEXT. Other byte or timeout -> RETRY.
- The response timer clears on every state entry and on every accepted byte.
- NEXT (1 cycle): retry_cnt=0. If cmd_idx=3 -> STREAM, else cmd_idx+1 -> SEND.
- RETRY (1 cycle): retry_cnt+1. If the new value equals MAX_RETRIES -> FAIL, else -> SEND with the same cmd_idx.
- FAIL: init_failed=1, send_command=0, received bytes ignored. restart -> SEND, cmd_idx=0.
- STREAM: init_done=1. Bytes are collected by byte_idx 0..2.
  - byte_idx 0 accepts a byte only if bit3=1; otherwise the byte is discarded (resync).
  - Byte2 completes the packet. The next cycle registers dx={b0[4],b1}, dy={b0[5],b2}, buttons=b0[2:0], overflow=b0[7:6], pulses packet_valid, and sets byte_idx=0.
  - Gap counter: if byte_idx!=0 and PKT_GAP cycles pass without a byte, byte_idx=0 and the partial packet is dropped with no strobe.
  - restart -> SEND, cmd_idx=0, byte_idx=0, init_done=0.
- restart is ignored in states other than STREAM and FAIL.
- Simultaneous command_was_sent and received_data_en in SEND: take the transition to WAIT_ACK and evaluate the byte in the same cycle as if in WAIT_ACK.
- Reset mid-operation returns to the reset state regardless of the controller transfer in progress; send_command drops in the next cycle.
- Output fields hold their last packet values until the next packet_valid.

Test Plan:
- Clean init: mouse model ACKs FA, then sends AA,00 after FF; FA after F3, 0x64 and F4 -> commands seen in order FF,F3,64,F4; init_done=1 one cycle after the last FA; init_failed=0.
- Resend: FE after F3, then FA -> F3 sent twice, init completes, retry_cnt back to 0 before 0x64.
- Give-up: error_communication_timed_out on every FF attempt (MAX_RETRIES=3) -> exactly 3 FF attempts, init_failed=1, send_command stays 0. restart pulse -> FF sent again.
- Response timeout (RESP_TIMEOUT=1000): no byte after FF ACK -> FF reissued after 1000 cycles. BAT byte 0xFC -> FF reissued.
- Packet: in STREAM, bytes 0x39,0x05,0xFB -> packet_valid pulse, dx=0x105 (-251), dy=0x1FB (-5), buttons=3'b001, overflow=0. Leading byte 0x05 (bit3=0) -> discarded, no strobe.
- Gap (PKT_GAP=200): 0x08, 0x10, then 250 idle cycles, then 0x08,0x01,0x02 -> single packet_valid with dx=1, dy=2.
